dm_cache_ctrl: RTL

Sequencing controller for the single-level, direct-mapped, write-back, write-allocate cache. It owns the tag/valid/dirty/data arrays and the hit/miss state machine. It sits between the processor's 32-bit word request port and the 128-bit main-memory line port. On each processor request it performs tag compare, dirty-victim write-back and line allocate, then completes the access.

---
 rtl/dm_cache_ctrl_if.sv | 43 ++++
 rtl/dm_cache_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl_if
// Brief    : Processor word port and main-memory line port of the cache.
// Revision : 1.0 - initial release
// ============================================================================
interface dm_cache_ctrl_if #(
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int MAIN_MEM_DATA_WIDTH = 128
);
    logic                           cpu_valid;
    logic                           cpu_rw;
    logic [ADDRESS_WIDTH-1:0]       cpu_addr;
    logic [DATA_WIDTH-1:0]          cpu_wdata;
    logic [DATA_WIDTH-1:0]          cpu_rdata;
    logic                           cpu_ready;

    logic                           mem_valid;
    logic                           mem_rw;
    logic [ADDRESS_WIDTH-1:0]       mem_addr;
    logic [MAIN_MEM_DATA_WIDTH-1:0] mem_wdata;
    logic [MAIN_MEM_DATA_WIDTH-1:0] mem_rdata;
    logic                           mem_ready;

    logic                           hit;
    logic                           miss;

    // Cache controller side.
    modport slave (
        input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_valid, mem_rw, mem_addr, mem_wdata,
        output hit, miss
    );

    // Processor / memory environment side.
    modport master (
        output cpu_valid, cpu_rw, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_valid, mem_rw, mem_addr, mem_wdata,
        input  hit, miss
    );
endinterface
`default_nettype wire

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Brief    : Direct-mapped, write-back, write-allocate cache controller.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int MAIN_MEM_DATA_WIDTH = 128,
    parameter int NUM_BLOCKS          = 4,
    parameter int INDEX_WIDTH         = 2,
    parameter int TAG_WIDTH           = 26
) (
    input  logic             clk,
    input  logic             rst,
    dm_cache_ctrl_if.slave   bus
);

    localparam int c_OFFSET_WIDTH   = $clog2(MAIN_MEM_DATA_WIDTH / 8);
    localparam int c_WORD_SEL_WIDTH = $clog2(MAIN_MEM_DATA_WIDTH / DATA_WIDTH);
    localparam int c_BYTE_BITS      = c_OFFSET_WIDTH - c_WORD_SEL_WIDTH;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_COMPARE    = 2'd1;
    localparam logic [1:0] c_WRITE_BACK = 2'd2;
    localparam logic [1:0] c_ALLOCATE   = 2'd3;

    logic [1:0]                     r_state;

    logic [NUM_BLOCKS-1:0]          r_valid;
    logic [NUM_BLOCKS-1:0]          r_dirty;
    logic [TAG_WIDTH-1:0]           r_tag  [NUM_BLOCKS];
    logic [MAIN_MEM_DATA_WIDTH-1:0] r_data [NUM_BLOCKS];

    logic                           r_req_rw;
    logic [TAG_WIDTH-1:0]           r_req_tag;
    logic [INDEX_WIDTH-1:0]         r_req_idx;
    logic [c_WORD_SEL_WIDTH-1:0]    r_req_word;
    logic [DATA_WIDTH-1:0]          r_req_wdata;

    logic                           r_cpu_ready;
    logic [DATA_WIDTH-1:0]          r_cpu_rdata;
    logic                           r_mem_valid;
    logic                           r_mem_rw;
    logic [ADDRESS_WIDTH-1:0]       r_mem_addr;
    logic [MAIN_MEM_DATA_WIDTH-1:0] r_mem_wdata;
    logic                           r_hit;
    logic                           r_miss;

    logic [TAG_WIDTH-1:0]           w_cpu_tag;
    logic [INDEX_WIDTH-1:0]         w_cpu_idx;
    logic [c_WORD_SEL_WIDTH-1:0]    w_cpu_word;
    logic [c_BYTE_BITS-1:0]         w_unused_byte_bits;
    logic                           w_accept;
    logic                           w_lookup_hit;
    logic                           w_victim_dirty;
    logic [DATA_WIDTH-1:0]          w_sel_word;
    logic [ADDRESS_WIDTH-1:0]       w_wb_addr;
    logic [ADDRESS_WIDTH-1:0]       w_alloc_addr;

    assign w_cpu_tag          = bus.cpu_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign w_cpu_idx          = bus.cpu_addr[c_OFFSET_WIDTH +: INDEX_WIDTH];
    assign w_cpu_word         = bus.cpu_addr[c_OFFSET_WIDTH-1 -: c_WORD_SEL_WIDTH];
    assign w_unused_byte_bits = bus.cpu_addr[c_BYTE_BITS-1:0];

    // The cpu_ready cycle sits in IDLE but must not re-accept the held request.
    assign w_accept       = (r_state == c_IDLE) && bus.cpu_valid && !r_cpu_ready;
    assign w_lookup_hit   = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
    assign w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];
    assign w_sel_word     = r_data[r_req_idx][int'(r_req_word) * DATA_WIDTH +: DATA_WIDTH];
    assign w_wb_addr      = {r_tag[r_req_idx], r_req_idx, {c_OFFSET_WIDTH{1'b0}}};
    assign w_alloc_addr   = {r_req_tag, r_req_idx, {c_OFFSET_WIDTH{1'b0}}};

    // r_hit/r_miss are resolved one cycle early so that the COMPARE-cycle
    // pulses come straight from flops; a refill always re-compares as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_mem_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_req_rw    <= 1'b0;
            r_req_tag   <= '0;
            r_req_idx   <= '0;
            r_req_word  <= '0;
            r_req_wdata <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_req_rw    <= bus.cpu_rw;
                        r_req_tag   <= w_cpu_tag;
                        r_req_idx   <= w_cpu_idx;
                        r_req_word  <= w_cpu_word;
                        r_req_wdata <= bus.cpu_wdata;
                        r_hit       <= w_lookup_hit;
                        r_miss      <= !w_lookup_hit;
                        r_state     <= c_COMPARE;
                    end
                end
                c_COMPARE: begin
                    if (r_hit) begin
                        if (r_req_rw) begin
                            r_data[r_req_idx][int'(r_req_word) * DATA_WIDTH +: DATA_WIDTH] <= r_req_wdata;
                            r_dirty[r_req_idx] <= 1'b1;
                        end else begin
                            r_cpu_rdata <= w_sel_word;
                        end
                        r_cpu_ready <= 1'b1;
                        r_state     <= c_IDLE;
                    end else if (w_victim_dirty) begin
                        r_mem_valid <= 1'b1;
                        r_mem_rw    <= 1'b1;
                        r_mem_addr  <= w_wb_addr;
                        r_mem_wdata <= r_data[r_req_idx];
                        r_state     <= c_WRITE_BACK;
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_rw    <= 1'b0;
                        r_mem_addr  <= w_alloc_addr;
                        r_state     <= c_ALLOCATE;
                    end
                end
                c_WRITE_BACK: begin
                    if (bus.mem_ready) begin
                        r_mem_rw   <= 1'b0;
                        r_mem_addr <= w_alloc_addr;
                        r_state    <= c_ALLOCATE;
                    end
                end
                c_ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_data[r_req_idx]  <= bus.mem_rdata;
                        r_tag[r_req_idx]   <= r_req_tag;
                        r_valid[r_req_idx] <= 1'b1;
                        r_dirty[r_req_idx] <= 1'b0;
                        r_mem_valid        <= 1'b0;
                        r_hit              <= 1'b1;
                        r_state            <= c_COMPARE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_rw    = r_mem_rw;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;

endmodule
`default_nettype wire
